// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard controller for a 5-stage ARM pipeline (F,D,E,M,W). It tracks a shadow copy
// of the E/M/W control fields and uses it to produce these signals:
// - stall and flush controls for the F/D and D/E pipeline registers
// - E-stage forwarding selects
// - saturating debug counters for load-use stalls and F/D flushes

module pipe_hazard_ctrl #(
   parameter int RA_W  = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [RA_W-1:0]  RA1D,
   input  logic [RA_W-1:0]  RA2D,
   input  logic [RA_W-1:0]  WA3D,
   input  logic             RegWriteD,
   input  logic             MemtoRegD,
   input  logic             PCSrcD,
   input  logic             CondExE,
   input  logic             BranchTakenE,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   // r15 is the PC. Reads of r15 come from the PC+8 path, so they never forward.
   localparam logic [RA_W-1:0] PC_REG = RA_W'(15);

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_W   = 2'b01;
   localparam logic [1:0] FWD_M   = 2'b10;

   // Shadow E stage
   logic            e_v;
   logic [RA_W-1:0] e_ra1, e_ra2, e_wa3;
   logic            e_rw, e_mr, e_pcs;
   // Shadow M stage
   logic            m_v;
   logic [RA_W-1:0] m_wa3;
   logic            m_rw, m_pcs;
   // Shadow W stage
   logic            w_v;
   logic [RA_W-1:0] w_wa3;
   logic            w_rw, w_pcs;

   // Effective controls: a stored control bit counts only when its stage holds a valid instruction.
   logic e_mr_eff, e_pcs_eff, m_rw_eff, m_pcs_eff, w_rw_eff, w_pcs_eff;
   logic ldr_stall, pc_wr_pend;

   assign e_mr_eff  = e_mr  & e_v;
   assign e_pcs_eff = e_pcs & e_v;
   assign m_rw_eff  = m_rw  & m_v;
   assign m_pcs_eff = m_pcs & m_v;
   assign w_rw_eff  = w_rw  & w_v;
   assign w_pcs_eff = w_pcs & w_v;

   function automatic logic reg_match(input logic [RA_W-1:0] ra, input logic [RA_W-1:0] wa);
      return (ra == wa) && (ra != PC_REG);
   endfunction

   // A load-use stall happens when D reads a register that the load now in E will write.
   assign ldr_stall  = (reg_match(RA1D, e_wa3) | reg_match(RA2D, e_wa3)) & e_mr_eff;
   // A PC write is pending while a PC-writing instruction sits in D, E or M.
   assign pc_wr_pend = PCSrcD | e_pcs_eff | m_pcs_eff;

   assign StallF = ldr_stall | pc_wr_pend;
   assign StallD = ldr_stall;
   assign FlushD = pc_wr_pend | w_pcs_eff | BranchTakenE;
   assign FlushE = ldr_stall | BranchTakenE;

   // Forwarding selects for the E-stage operands. M is newer than W, so M wins.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path through it can infer a latch.
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      if (reg_match(e_ra1, m_wa3) && m_rw_eff)      ForwardAE = FWD_M;
      else if (reg_match(e_ra1, w_wa3) && w_rw_eff) ForwardAE = FWD_W;
      if (reg_match(e_ra2, m_wa3) && m_rw_eff)      ForwardBE = FWD_M;
      else if (reg_match(e_ra2, w_wa3) && w_rw_eff) ForwardBE = FWD_W;
   end

   // The shadow pipeline advances one stage on every clock and never stalls.
   // FlushE loads a bubble into E. CondExE squashes the writes of the instruction leaving E.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state updates use non-blocking assignments, so every stage samples the pre-edge value of the stage before it.
      if (reset) begin
         e_v   <= 1'b0;  e_ra1 <= '0;  e_ra2 <= '0;  e_wa3 <= '0;
         e_rw  <= 1'b0;  e_mr  <= 1'b0; e_pcs <= 1'b0;
         m_v   <= 1'b0;  m_wa3 <= '0;  m_rw  <= 1'b0; m_pcs <= 1'b0;
         w_v   <= 1'b0;  w_wa3 <= '0;  w_rw  <= 1'b0; w_pcs <= 1'b0;
      end else begin
         if (FlushE) begin
            e_v   <= 1'b0;  e_ra1 <= '0;  e_ra2 <= '0;  e_wa3 <= '0;
            e_rw  <= 1'b0;  e_mr  <= 1'b0; e_pcs <= 1'b0;
         end else begin
            e_v   <= 1'b1;
            e_ra1 <= RA1D;
            e_ra2 <= RA2D;
            e_wa3 <= WA3D;
            e_rw  <= RegWriteD;
            e_mr  <= MemtoRegD;
            e_pcs <= PCSrcD;
         end
         m_v   <= e_v;
         m_wa3 <= e_wa3;
         m_rw  <= e_rw  & CondExE;
         m_pcs <= e_pcs & CondExE;
         w_v   <= m_v;
         w_wa3 <= m_wa3;
         w_rw  <= m_rw;
         w_pcs <= m_pcs;
      end
   end

   // Debug event counters. Each one stops at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         StallCnt <= '0;
         FlushCnt <= '0;
      end else begin
         if (ldr_stall && (StallCnt != '1)) StallCnt <= StallCnt + CNT_W'(1);
         if (FlushD    && (FlushCnt != '1)) FlushCnt <= FlushCnt + CNT_W'(1);
      end
   end

endmodule
